// File: rtl/rgb2grey_stream_if.sv
// Pixel-stream handshake bundle for rgb2grey_stream: RGB input side (s_*) and grey output side (m_*).
// The converter uses the slave modport; the pixel source/sink environment uses master.
interface rgb2grey_stream_if #(
  parameter int unsigned CW = 8
);
  logic            s_valid;
  logic            s_ready;
  logic [3*CW-1:0] s_pixel;
  logic            s_last;
  logic            m_valid;
  logic            m_ready;
  logic [CW-1:0]   m_grey;
  logic            m_last;

  modport slave (
    input  s_valid, s_pixel, s_last, m_ready,
    output s_ready, m_valid, m_grey, m_last
  );

  modport master (
    output s_valid, s_pixel, s_last, m_ready,
    input  s_ready, m_valid, m_grey, m_last
  );
endinterface

// File: rtl/rgb2grey_stream.sv
// Pipelined RGB-to-grey converter: 3-stage multiply / sum+round / saturate, valid/ready stream, stats.
// Optional RGB2GREY_REG_READY_EN adds a 2-entry skid buffer so s_ready is registered.
module rgb2grey_stream #(
  parameter int unsigned CW     = 8,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned CR_DEF = 77,
  parameter int unsigned CG_DEF = 150,
  parameter int unsigned CB_DEF = 29,
  parameter int unsigned CNTW   = 32
) (
  input  logic            clk,
  input  logic            rst,
  rgb2grey_stream_if.slave strm,
  input  logic            cfg_we,
  input  logic [FRAC:0]   cfg_cr,
  input  logic [FRAC:0]   cfg_cg,
  input  logic [FRAC:0]   cfg_cb,
  input  logic            stat_clr,
  output logic [CNTW-1:0] pix_cnt,
  output logic            sat_flag
);
  localparam int unsigned PW = CW + FRAC + 1;
  localparam int unsigned SW = CW + FRAC + 3;
  localparam int unsigned YW = CW + 3;
  localparam logic [SW-1:0] RND = SW'(1) << (FRAC - 1);

  logic [FRAC:0]   cr, cg, cb;
  logic            adv;
  logic            in_valid, in_last;
  logic [3*CW-1:0] in_pix;
  logic [FRAC:0]   in_cr, in_cg, in_cb;

  logic            v1, v2, v3;
  logic            l1, l2, l3;
  logic [PW-1:0]   p_r, p_g, p_b;
  logic [SW-1:0]   sum;
  logic [YW-1:0]   y;
  logic            y_sat;
  logic [CW-1:0]   grey;

  assign adv          = !v3 || strm.m_ready;
  assign strm.m_valid = v3;
  assign strm.m_last  = l3;
  assign strm.m_grey  = grey;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr <= (FRAC+1)'(CR_DEF);
      cg <= (FRAC+1)'(CG_DEF);
      cb <= (FRAC+1)'(CB_DEF);
    end else if (cfg_we) begin
      cr <= cfg_cr;
      cg <= cfg_cg;
      cb <= cfg_cb;
    end
  end

`ifdef RGB2GREY_REG_READY_EN
  // Each entry snapshots the coefficients at accept time, so a buffered pixel
  // is converted with the values that were live when it entered.
  typedef struct packed {
    logic [3*CW-1:0] pix;
    logic            last;
    logic [FRAC:0]   cr;
    logic [FRAC:0]   cg;
    logic [FRAC:0]   cb;
  } skid_t;

  skid_t      skid [2];
  logic       wr_ptr, rd_ptr, full, push, pop;
  logic [1:0] fill, fill_nxt;

  assign push         = strm.s_valid && !full;
  assign pop          = adv && (fill != 2'd0);
  assign fill_nxt     = fill + {1'b0, push} - {1'b0, pop};
  assign strm.s_ready = !full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      fill   <= 2'd0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= !wr_ptr;
      if (pop)  rd_ptr <= !rd_ptr;
      fill <= fill_nxt;
      full <= (fill_nxt == 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (push) skid[wr_ptr] <= {strm.s_pixel, strm.s_last, cr, cg, cb};
  end

  always_comb begin
    in_valid = (fill != 2'd0);
    in_pix   = skid[rd_ptr].pix;
    in_last  = skid[rd_ptr].last;
    in_cr    = skid[rd_ptr].cr;
    in_cg    = skid[rd_ptr].cg;
    in_cb    = skid[rd_ptr].cb;
  end
`else
  assign in_valid     = strm.s_valid;
  assign in_pix       = strm.s_pixel;
  assign in_last      = strm.s_last;
  assign in_cr        = cr;
  assign in_cg        = cg;
  assign in_cb        = cb;
  assign strm.s_ready = adv;
`endif

  always_comb begin
    y     = sum[SW-1:FRAC];
    y_sat = |y[YW-1:CW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      l1   <= 1'b0;
      l2   <= 1'b0;
      l3   <= 1'b0;
      p_r  <= '0;
      p_g  <= '0;
      p_b  <= '0;
      sum  <= '0;
      grey <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      l1 <= in_valid && in_last;
      if (in_valid) begin
        p_r <= PW'(in_pix[3*CW-1:2*CW]) * PW'(in_cr);
        p_g <= PW'(in_pix[2*CW-1:CW])   * PW'(in_cg);
        p_b <= PW'(in_pix[CW-1:0])      * PW'(in_cb);
      end
      v2 <= v1;
      l2 <= l1;
      if (v1) sum <= SW'(p_r) + SW'(p_g) + SW'(p_b) + RND;
      v3 <= v2;
      l3 <= l2;
      if (v2) grey <= y_sat ? '1 : y[CW-1:0];
    end
  end

  // Clear wins over both the handshake increment and a saturating load into S3.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (stat_clr) begin
      pix_cnt  <= '0;
      sat_flag <= 1'b0;
    end else begin
      if (v3 && strm.m_ready) pix_cnt <= pix_cnt + 1'b1;
      if (adv && v2 && y_sat) sat_flag <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rgb2grey_stream.sv
// Directed, table-driven bench for rgb2grey_stream (CW=8, FRAC=8, CNTW=4).
// Outputs are checked in order against an expectation queue filled as pixels are accepted.
module tb_rgb2grey_stream;
`ifdef RGB2GREY_REG_READY_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we, stat_clr;
  logic [8:0] cfg_cr, cfg_cg, cfg_cb;
  logic [3:0] pix_cnt;
  logic       sat_flag;

  always #5 clk = ~clk;

  rgb2grey_stream_if #(.CW(8)) io ();

  rgb2grey_stream #(.CW(8), .FRAC(8), .CNTW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .strm     (io),
    .cfg_we   (cfg_we),
    .cfg_cr   (cfg_cr),
    .cfg_cg   (cfg_cg),
    .cfg_cb   (cfg_cb),
    .stat_clr (stat_clr),
    .pix_cnt  (pix_cnt),
    .sat_flag (sat_flag)
  );

  typedef struct {
    logic [23:0] pix;
    logic        last;
    logic [7:0]  grey;
  } vec_t;

  typedef struct packed {
    logic [7:0] grey;
    logic       last;
  } exp_t;

  vec_t vecs [13];
  exp_t q [$];
  exp_t e_mon;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic       held = 1'b0;
  logic [7:0] held_grey;
  logic       held_last;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send(input logic [23:0] pix, input logic last, input logic [7:0] grey, input bit track);
    bit ok = 1'b0;
    io.s_pixel = pix;
    io.s_last  = last;
    io.s_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (io.s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 32'd1);
    if (ok && track) q.push_back({grey, last});
    @(posedge clk); #1;
    io.s_valid = 1'b0;
    io.s_last  = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic load_coef(input logic [8:0] r, input logic [8:0] g, input logic [8:0] b);
    cfg_cr = r; cfg_cg = g; cfg_cb = b;
    cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      held <= 1'b0;
    end else begin
      if (io.m_valid && !io.m_ready) begin
        if (held) begin
          chk("hold_grey", 32'(io.m_grey), 32'(held_grey));
          chk("hold_last", 32'(io.m_last), 32'(held_last));
        end
        held      <= 1'b1;
        held_grey <= io.m_grey;
        held_last <= io.m_last;
      end else begin
        held <= 1'b0;
      end
      if (io.m_valid && io.m_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got grey %0d, required no output", io.m_grey);
        end else begin
          e_mon = q.pop_front();
          chk("grey", 32'(io.m_grey), 32'(e_mon.grey));
          chk("last", 32'(io.m_last), 32'(e_mon.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    logic [7:0] v;

    vecs[0] = '{24'hFF0000, 1'b0, 8'd77};
    vecs[1] = '{24'h00FF00, 1'b0, 8'd149};
    vecs[2] = '{24'h0000FF, 1'b0, 8'd29};
    vecs[3] = '{24'hFFFFFF, 1'b0, 8'd255};
    vecs[4] = '{24'h000000, 1'b1, 8'd0};
    vecs[5]  = '{24'h0A0A0A, 1'b0, 8'd10};
    vecs[6]  = '{24'h141414, 1'b0, 8'd20};
    vecs[7]  = '{24'h1E1E1E, 1'b0, 8'd30};
    vecs[8]  = '{24'h282828, 1'b0, 8'd40};
    vecs[9]  = '{24'h323232, 1'b1, 8'd50};
    vecs[10] = '{24'h3C3C3C, 1'b0, 8'd60};
    vecs[11] = '{24'h464646, 1'b0, 8'd70};
    vecs[12] = '{24'h505050, 1'b0, 8'd80};

    rst = 1'b1;
    io.s_valid = 1'b0; io.s_pixel = '0; io.s_last = 1'b0; io.m_ready = 1'b1;
    cfg_we = 1'b0; cfg_cr = '0; cfg_cg = '0; cfg_cb = '0; stat_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(io.m_valid), 32'd0);
    chk("rst_m_grey", 32'(io.m_grey), 32'd0);
    chk("rst_m_last", 32'(io.m_last), 32'd0);
    chk("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    chk("rst_sat_flag", 32'(sat_flag), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_s_ready", 32'(io.s_ready), 32'd1);

    // Latency from accept edge to m_valid.
    send(24'hFF0000, 1'b0, 8'd77, 1'b1);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (io.m_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(LAT));
    drain();

    for (int k = 0; k < 5; k++) send(vecs[k].pix, vecs[k].last, vecs[k].grey, 1'b1);
    drain();
    chk("cnt_after_primaries", 32'(pix_cnt), 32'd6);

    // Burst of 8 with m_ready low for 5 edges mid-burst.
    fork
      begin
        for (int k = 5; k < 13; k++) send(vecs[k].pix, vecs[k].last, vecs[k].grey, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 io.m_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_s_ready", 32'(io.s_ready), 32'd0);
        chk("stall_m_valid", 32'(io.m_valid), 32'd1);
        @(posedge clk); #1;
        io.m_ready = 1'b1;
      end
    join
    drain();
    chk("cnt_after_burst", 32'(pix_cnt), 32'd14);

    // Saturation with all coefficients at 1.0.
    load_coef(9'd256, 9'd256, 9'd256);
    send(24'h808080, 1'b0, 8'd255, 1'b1);
    drain();
    chk("sat_set", 32'(sat_flag), 32'd1);
    chk("cnt_15", 32'(pix_cnt), 32'd15);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("clr_sat", 32'(sat_flag), 32'd0);
    chk("clr_cnt", 32'(pix_cnt), 32'd0);

    // stat_clr on the same edge as an output handshake.
    send(24'h808080, 1'b0, 8'd255, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (io.m_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("prio_seen", 32'(seen), 32'd1);
    stat_clr = 1'b1;
    @(posedge clk); #1;
    stat_clr = 1'b0;
    chk("prio_cnt", 32'(pix_cnt), 32'd0);
    chk("prio_sat", 32'(sat_flag), 32'd0);

    // cfg_we on the accept edge: that pixel keeps the old coefficients.
    load_coef(9'd77, 9'd150, 9'd29);
    io.s_pixel = 24'hFF0000; io.s_last = 1'b0; io.s_valid = 1'b1;
    cfg_cr = 9'd128; cfg_cg = 9'd100; cfg_cb = 9'd60; cfg_we = 1'b1;
    @(negedge clk);
    chk("cfg_same_ready", 32'(io.s_ready), 32'd1);
    q.push_back({8'd77, 1'b0});
    @(posedge clk); #1;
    io.s_valid = 1'b0; cfg_we = 1'b0;
    send(24'hFF0000, 1'b0, 8'd128, 1'b1);
    send(24'h00FF00, 1'b0, 8'd100, 1'b1);
    drain();
    chk("cnt_after_cfg", 32'(pix_cnt), 32'd3);

    // Reset with three pixels in flight.
    for (int k = 0; k < 3; k++) send(24'hFFFFFF, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_m_valid", 32'(io.m_valid), 32'd0);
    chk("midrst_pix_cnt", 32'(pix_cnt), 32'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) send(vecs[k].pix, vecs[k].last, vecs[k].grey, 1'b1);
    drain();
    chk("cnt_after_rst", 32'(pix_cnt), 32'd3);

    // 14 more outputs: 17 handshakes since reset wraps the 4-bit counter to 1.
    for (int i = 1; i <= 14; i++) begin
      v = 8'(i * 7);
      send({v, v, v}, i == 5, v, 1'b1);
    end
    drain();
    chk("cnt_wrap", 32'(pix_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
